// File: rtl/vga_rect_fill.sv
// Raster-order rectangle fill: 1 pixel write/clk, first write 1 cycle after accept, done_o 1 cycle after last.
// Ready only in IDLE (commands ignored while filling); VGA_RECT_CLIP_EN suppresses we_o outside HD x VD.
module vga_rect_fill #(
  parameter int X_BITS     = 11,
  parameter int Y_BITS     = 11,
  parameter int COLOR_BITS = 2,
  parameter int HD         = 1280,
  parameter int VD         = 1024
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [X_BITS-1:0]     cmd_x_i,
  input  logic [Y_BITS-1:0]     cmd_y_i,
  input  logic [X_BITS-1:0]     cmd_w_i,
  input  logic [Y_BITS-1:0]     cmd_h_i,
  input  logic [COLOR_BITS-1:0] cmd_color_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [X_BITS-1:0]     addr_x_o,
  output logic [Y_BITS-1:0]     addr_y_o,
  output logic [COLOR_BITS-1:0] color_o,
  output logic                  we_o
);

`ifdef VGA_RECT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  localparam logic [X_BITS:0] ONE_X = (X_BITS+1)'(1);
  localparam logic [Y_BITS:0] ONE_Y = (Y_BITS+1)'(1);
  localparam logic [X_BITS:0] HD_X  = (X_BITS+1)'(HD);
  localparam logic [Y_BITS:0] VD_Y  = (Y_BITS+1)'(VD);

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [X_BITS:0]       cx_q, cx_d, xs_q, xs_d, xe_q, xe_d;
  logic [Y_BITS:0]       cy_q, cy_d, ye_q, ye_d;
  logic [X_BITS-1:0]     ax_q, ax_d;
  logic [Y_BITS-1:0]     ay_q, ay_d;
  logic [COLOR_BITS-1:0] color_q, color_d;
  logic                  we_q, we_d, done_q, done_d;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      cx_q    <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      cy_q    <= '0;
      ye_q    <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      cy_q    <= cy_d;
      ye_q    <= ye_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      color_q <= color_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    xs_d    = xs_q;
    xe_d    = xe_q;
    cy_d    = cy_q;
    ye_d    = ye_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    color_d = color_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_w_i == '0 || cmd_h_i == '0) begin
            done_d = 1'b1;
          end else begin
            // End coordinates are one bit wider so x0+w-1 never wraps in the compare.
            state_d = FILL;
            xs_d    = {1'b0, cmd_x_i};
            xe_d    = {1'b0, cmd_x_i} + {1'b0, cmd_w_i} - ONE_X;
            ye_d    = {1'b0, cmd_y_i} + {1'b0, cmd_h_i} - ONE_Y;
            cx_d    = {1'b0, cmd_x_i};
            cy_d    = {1'b0, cmd_y_i};
            color_d = cmd_color_i;
          end
        end
      end
      FILL: begin
        if (cx_q == xe_q) begin
          if (cy_q == ye_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cx_d = xs_q;
            cy_d = cy_q + ONE_Y;
          end
        end else begin
          cx_d = cx_q + ONE_X;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == FILL) begin
      ax_d = cx_d[X_BITS-1:0];
      ay_d = cy_d[Y_BITS-1:0];
      we_d = !CLIP || (cx_d < HD_X && cy_d < VD_Y);
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q == FILL);
  assign done_o      = done_q;
  assign addr_x_o    = ax_q;
  assign addr_y_o    = ay_q;
  assign color_o     = color_q;
  assign we_o        = we_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Bench for vga_rect_fill: per-cycle scoreboard from a command-level pixel list model, plus directed literals.
module tb_vga_rect_fill;
  localparam int XB = 11, YB = 11, CB = 2, HD = 1280, VD = 1024;

  logic          clk_i = 1'b0, arstn_i = 1'b1;
  logic          cmd_valid_i = 1'b0;
  logic [XB-1:0] cmd_x_i = '0, cmd_w_i = '0;
  logic [YB-1:0] cmd_y_i = '0, cmd_h_i = '0;
  logic [CB-1:0] cmd_color_i = '0;
  logic          cmd_ready_o, busy_o, done_o, we_o;
  logic [XB-1:0] addr_x_o;
  logic [YB-1:0] addr_y_o;
  logic [CB-1:0] color_o;

  vga_rect_fill #(.X_BITS(XB), .Y_BITS(YB), .COLOR_BITS(CB), .HD(HD), .VD(VD)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_x_i(cmd_x_i), .cmd_y_i(cmd_y_i), .cmd_w_i(cmd_w_i), .cmd_h_i(cmd_h_i),
    .cmd_color_i(cmd_color_i), .busy_o(busy_o), .done_o(done_o), .addr_x_o(addr_x_o),
    .addr_y_o(addr_y_o), .color_o(color_o), .we_o(we_o));

  always #5 clk_i = ~clk_i;

`ifdef VGA_RECT_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct {bit we; bit done; bit busy; bit rdy; int x; int y; int c;} rec_t;
  typedef struct {int cyc; int x; int y; int c;} wl_t;

  rec_t cur = '{0, 0, 0, 1, 0, 0, 0};
  rec_t q[$];
  wl_t  wlog[$];
  int   dlog[$];
  int   busy_cnt = 0;
  int   cyc = 0;
  int   tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Command-level model: a command expands to its whole pixel list in raster order.
  task automatic expand(input int x0, input int y0, input int w, input int h, input int c);
    rec_t r;
    r = cur;
    if (w == 0 || h == 0) begin
      r.we = 0; r.done = 1; r.busy = 0; r.rdy = 1;
      q.push_back(r);
      return;
    end
    for (int j = 0; j < h; j++)
      for (int i = 0; i < w; i++) begin
        int X, Y;
        X = x0 + i; Y = y0 + j;
        r.x = X % (1 << XB); r.y = Y % (1 << YB); r.c = c;
        r.we = CLIP ? (X < HD && Y < VD) : 1'b1;
        r.done = 0; r.busy = 1; r.rdy = 0;
        q.push_back(r);
      end
    r.we = 0; r.done = 1; r.busy = 0; r.rdy = 1;
    q.push_back(r);
  endtask

  always @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      q.delete();
      cur = '{0, 0, 0, 1, 0, 0, 0};
    end else begin
      if (cur.rdy && cmd_valid_i)
        expand(int'(cmd_x_i), int'(cmd_y_i), int'(cmd_w_i), int'(cmd_h_i), int'(cmd_color_i));
      if (q.size() > 0) cur = q.pop_front();
      else begin
        cur.we = 0; cur.done = 0; cur.busy = 0; cur.rdy = 1;
      end
    end
  end

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    chk("we_o", we_o, cur.we);
    chk("done_o", done_o, cur.done);
    chk("busy_o", busy_o, cur.busy);
    chk("cmd_ready_o", cmd_ready_o, cur.rdy);
    chk("addr_x_o", addr_x_o, cur.x);
    chk("addr_y_o", addr_y_o, cur.y);
    chk("color_o", color_o, cur.c);
    if (we_o) wlog.push_back('{cyc, int'(addr_x_o), int'(addr_y_o), int'(color_o)});
    if (done_o) dlog.push_back(cyc);
    if (busy_o) busy_cnt++;
  end

  task automatic clear_logs();
    wlog.delete(); dlog.delete(); busy_cnt = 0;
  endtask

  // Called at a negedge; returns the cycle index right after the accepting edge.
  task automatic send(input int x, input int y, input int w, input int h, input int c,
                      input bit keep, output int acc);
    int n;
    cmd_x_i = XB'(x); cmd_y_i = YB'(y); cmd_w_i = XB'(w); cmd_h_i = YB'(h);
    cmd_color_i = CB'(c); cmd_valid_i = 1'b1;
    n = 0;
    while (!cur.rdy && n < 500) begin @(negedge clk_i); n++; end
    if (n >= 500) chk("accept_timeout", 0, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    acc = cyc;
    if (!keep) cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(cur.rdy && q.size() == 0) && n < 500) begin @(negedge clk_i); n++; end
    if (n >= 500) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk_i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    int acc, a1, a2;
    int ex[6], ey[6];
    ex = '{10, 11, 12, 10, 11, 12};
    ey = '{20, 20, 20, 21, 21, 21};
    #1 arstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_we", we_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_addr_x", addr_x_o, 0);
    arstn_i = 1'b1;
    @(negedge clk_i);

    // Basic 3x2 fill
    clear_logs();
    send(10, 20, 3, 2, 2, 0, acc);
    wait_idle();
    chk("t1_nwrites", wlog.size(), 6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) begin
      chk("t1_cyc", wlog[k].cyc, acc + k);
      chk("t1_x", wlog[k].x, ex[k]);
      chk("t1_y", wlog[k].y, ey[k]);
      chk("t1_c", wlog[k].c, 2);
    end
    chk("t1_ndone", dlog.size(), 1);
    if (dlog.size() > 0) chk("t1_done_cyc", dlog[0], acc + 6);

    // Zero width
    clear_logs();
    send(7, 9, 0, 5, 1, 0, acc);
    repeat (3) @(negedge clk_i);
    chk("t2_nwrites", wlog.size(), 0);
    chk("t2_ndone", dlog.size(), 1);
    if (dlog.size() > 0) chk("t2_done_cyc", dlog[0], acc);
    chk("t2_busy", busy_cnt, 0);

    // Back-to-back accept in the done cycle
    clear_logs();
    send(30, 40, 2, 2, 3, 1, a1);
    send(0, 0, 1, 1, 1, 0, a2);
    wait_idle();
    chk("t3_acc2", a2, a1 + 5);
    chk("t3_nwrites", wlog.size(), 5);
    if (wlog.size() == 5) begin
      chk("t3_cyc", wlog[4].cyc, a1 + 5);
      chk("t3_x", wlog[4].x, 0);
      chk("t3_y", wlog[4].y, 0);
      chk("t3_c", wlog[4].c, 1);
    end
    chk("t3_ndone", dlog.size(), 2);
    if (dlog.size() == 2) chk("t3_done2", dlog[1], a1 + 6);

    // Reset on the 3rd write
    clear_logs();
    send(100, 100, 4, 4, 1, 0, acc);
    while (cyc < acc + 2) @(negedge clk_i);
    chk("t4_we_before", we_o, 1);
    #2 arstn_i = 1'b0;
    #1;
    chk("t4_async_we", we_o, 0);
    chk("t4_async_ready", cmd_ready_o, 1);
    chk("t4_async_busy", busy_o, 0);
    chk("t4_async_x", addr_x_o, 0);
    chk("t4_async_color", color_o, 0);
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    clear_logs();
    repeat (10) @(negedge clk_i);
    chk("t4_no_writes", wlog.size(), 0);

`ifdef VGA_RECT_CLIP_EN
    clear_logs();
    send(1278, 1023, 4, 2, 3, 0, acc);
    wait_idle();
    chk("t5_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("t5_x0", wlog[0].x, 1278);
      chk("t5_x1", wlog[1].x, 1279);
      chk("t5_y1", wlog[1].y, 1023);
      chk("t5_cyc1", wlog[1].cyc, acc + 1);
    end
    if (dlog.size() > 0) chk("t5_done_cyc", dlog[0], acc + 8);
`else
    clear_logs();
    send(2046, 0, 3, 1, 1, 0, acc);
    wait_idle();
    chk("t5_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t5_x0", wlog[0].x, 2046);
      chk("t5_x1", wlog[1].x, 2047);
      chk("t5_x2", wlog[2].x, 0);
      chk("t5_cyc2", wlog[2].cyc, acc + 2);
    end
    if (dlog.size() > 0) chk("t5_done_cyc", dlog[0], acc + 3);
`endif

    // Random commands, checked every cycle by the scoreboard
    for (int n = 0; n < 40; n++) begin
      int x, y, w, h, c;
      bit keep;
      x = $urandom_range(0, 2047);
      y = $urandom_range(0, 2047);
      if (n % 3 == 0) begin x = $urandom_range(1270, 1279); y = $urandom_range(1018, 1023); end
      w = $urandom_range(0, 6);
      h = $urandom_range(0, 4);
      c = $urandom_range(0, 3);
      keep = $urandom_range(0, 1);
      send(x, y, w, h, c, keep, acc);
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end
    cmd_valid_i = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
